// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the unified-memory bus arbiter.
//   arb_state_e : IDLE (arbitrate), ACCESS (memory busy), RESP (data returned)
//   port_id_e   : PORT_F (instruction fetch), PORT_D (load/store)
// ----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_F = 1'b0,
      PORT_D = 1'b1
   } port_id_e;

   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_MAX_STARVE = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the fetch port, the load/store port and the memory-side port of the
// arbiter.
//   slave  : the arbiter's view (takes requests, drives the memory)
//   master : the environment's view (requesters plus the memory itself)
// Fetch:  f_req, f_addr -> f_gnt, f_rvalid, f_rdata
// Data:   d_req, d_we, d_addr, d_wdata, d_wmask -> d_gnt, d_rvalid, d_rdata
// Memory: mem_addr, mem_we, mem_wdata, mem_wmask -> mem_rdata
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  f_req;
   logic [ADDR_W-1:0]     f_addr;
   logic                  f_gnt;
   logic                  f_rvalid;
   logic [DATA_W-1:0]     f_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_wmask;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_W-1:0]     d_rdata;

   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wmask;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  f_req, f_addr,
      output f_gnt, f_rvalid, f_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_wmask,
      output d_gnt, d_rvalid, d_rdata,
      output mem_addr, mem_we, mem_wdata, mem_wmask,
      input  mem_rdata
   );

   modport master (
      output f_req, f_addr,
      input  f_gnt, f_rvalid, f_rdata,
      output d_req, d_we, d_addr, d_wdata, d_wmask,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_addr, mem_we, mem_wdata, mem_wmask,
      output mem_rdata
   );

endinterface : mem_bus_arbiter_if

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the fetch and load/store requesters.
// The data port wins a tie unless fetch has already been passed over
// MAX_STARVE times in a row.
//   f_req, d_req : raw requests
//   starve_cnt   : consecutive D grants taken while F was waiting
//   any_req      : at least one requester is asking
//   winner       : port to grant (only meaningful when any_req = 1)
// ----------------------------------------------------------------------------
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int MAX_STARVE = DEF_MAX_STARVE,
   parameter int CNT_W      = 3
) (
   input  logic             f_req,
   input  logic             d_req,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic             any_req,
   output port_id_e         winner
);

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

   // Priority select: D by default, F when alone or when starved
   always_comb begin
      any_req = f_req | d_req;
      winner  = PORT_D;
      if (f_req && d_req) begin
         if (starve_cnt == STARVE_MAX) begin
            winner = PORT_F;
         end else begin
            winner = PORT_D;
         end
      end else if (f_req) begin
         winner = PORT_F;
      end else begin
         winner = PORT_D;
      end
   end

endmodule : mem_arb_pick

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares a single-port fixed-latency memory between the instruction-fetch
// port (F) and the load/store port (D). One transaction at a time:
//   IDLE   : arbitrate, winner's gnt is asserted combinationally
//   ACCESS : MEM_LAT cycles, memory address/data driven from the latch;
//            mem_we only in the first ACCESS cycle
//   RESP   : one cycle, owner's rvalid pulses and mem_rdata is forwarded
//            and captured into that port's hold register
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_bus_arbiter_if.slave (fetch, data and memory signals)
// ----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int MAX_STARVE = DEF_MAX_STARVE
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_bus_arbiter_if.slave bus
);

   localparam int MASK_W = DATA_W / 8;
   localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int CNT_W  = $clog2(MAX_STARVE + 1);

   localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

   if (MEM_LAT < 1) begin : g_bad_mem_lat
      $error("mem_bus_arbiter: MEM_LAT must be at least 1");
   end
   if (MAX_STARVE < 1) begin : g_bad_max_starve
      $error("mem_bus_arbiter: MAX_STARVE must be at least 1");
   end

   arb_state_e          state_r;
   arb_state_e          state_s;
   logic [LAT_W-1:0]    lat_cnt_r;
   logic [LAT_W-1:0]    lat_cnt_s;
   logic [CNT_W-1:0]    starve_cnt_r;
   logic [CNT_W-1:0]    starve_cnt_s;
   logic                grant_s;
   logic                any_req_s;
   port_id_e            winner_s;

   port_id_e            owner_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [MASK_W-1:0]   wmask_r;
   logic                mem_we_r;
   logic [DATA_W-1:0]   f_hold_r;
   logic [DATA_W-1:0]   d_hold_r;

   logic                resp_f_s;
   logic                resp_d_s;

   mem_arb_pick #(
      .MAX_STARVE (MAX_STARVE),
      .CNT_W      (CNT_W)
   ) u_pick (
      .f_req      (bus.f_req),
      .d_req      (bus.d_req),
      .starve_cnt (starve_cnt_r),
      .any_req    (any_req_s),
      .winner     (winner_s)
   );

   // Saturating increment of the starvation counter
   function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] res;
      if (cnt == STARVE_MAX) begin
         res = cnt;
      end else begin
         res = cnt + CNT_W'(1);
      end
      return res;
   endfunction

   // FSM state, latency counter and starvation counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         lat_cnt_r    <= '0;
         starve_cnt_r <= '0;
      end else begin
         state_r      <= state_s;
         lat_cnt_r    <= lat_cnt_s;
         starve_cnt_r <= starve_cnt_s;
      end
   end

   // Next-state, grant and counter update logic
   always_comb begin
      state_s      = state_r;
      lat_cnt_s    = lat_cnt_r;
      starve_cnt_s = starve_cnt_r;
      grant_s      = 1'b0;
      case (state_r)
         IDLE: begin
            lat_cnt_s = '0;
            if (any_req_s) begin
               grant_s = 1'b1;
               state_s = ACCESS;
               if (winner_s == PORT_F) begin
                  starve_cnt_s = '0;
               end else if (bus.f_req) begin
                  // D taken while F waits: F has been passed over once more
                  starve_cnt_s = starve_inc(starve_cnt_r);
               end else begin
                  starve_cnt_s = '0;
               end
            end else begin
               // No request at all means F is not waiting
               state_s      = IDLE;
               starve_cnt_s = '0;
            end
         end
         ACCESS: begin
            if (lat_cnt_r == LAT_LAST) begin
               state_s   = RESP;
               lat_cnt_s = '0;
            end else begin
               state_s   = ACCESS;
               lat_cnt_s = lat_cnt_r + LAT_W'(1);
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s   = IDLE;
            lat_cnt_s = '0;
         end
      endcase
   end

   // Transaction latch, single-cycle write strobe and read-data hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_r  <= PORT_F;
         addr_r   <= '0;
         wdata_r  <= '0;
         wmask_r  <= '0;
         mem_we_r <= 1'b0;
         f_hold_r <= '0;
         d_hold_r <= '0;
      end else begin
         if (grant_s) begin
            owner_r <= winner_s;
            if (winner_s == PORT_D) begin
               addr_r  <= bus.d_addr;
               wdata_r <= bus.d_wdata;
               wmask_r <= bus.d_wmask;
            end else begin
               // Fetches are always reads
               addr_r  <= bus.f_addr;
               wdata_r <= '0;
               wmask_r <= '0;
            end
         end
         // High only in the first ACCESS cycle of a store
         mem_we_r <= grant_s && (winner_s == PORT_D) && bus.d_we;
         if (state_r == RESP) begin
            if (owner_r == PORT_F) begin
               f_hold_r <= bus.mem_rdata;
            end else begin
               d_hold_r <= bus.mem_rdata;
            end
         end
      end
   end

   assign resp_f_s = (state_r == RESP) && (owner_r == PORT_F);
   assign resp_d_s = (state_r == RESP) && (owner_r == PORT_D);

   // Grants are gated with rst_n so they drop the moment reset asserts
   assign bus.f_gnt     = rst_n & grant_s & (winner_s == PORT_F);
   assign bus.d_gnt     = rst_n & grant_s & (winner_s == PORT_D);

   assign bus.f_rvalid  = resp_f_s;
   assign bus.d_rvalid  = resp_d_s;
   assign bus.f_rdata   = resp_f_s ? bus.mem_rdata : f_hold_r;
   assign bus.d_rdata   = resp_d_s ? bus.mem_rdata : d_hold_r;

   assign bus.mem_addr  = addr_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_wdata = wdata_r;
   assign bus.mem_wmask = wmask_r;

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Two arbiter instances: u_dut1 with MEM_LAT=1 (single fetch sequence) and
// u_dut2 with MEM_LAT=2 (vector table, contention, withdrawal, reset).
// Each has a byte-masked memory model whose read data appears MEM_LAT edges
// after the address. Expected completions on u_dut2 are queued when a grant
// is seen and popped by a monitor on every rvalid.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT2 = 2;

   typedef struct {
      port_id_e    port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      port_id_e    port;
      logic        is_store;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   we_cnt2 = 0;
   int   gnt_cyc2 = -10;

   exp_t        sbq[$];
   exp_t        mon_e;
   vec_t        vecs[8];
   port_id_e    order[10];
   logic [31:0] mem1 [0:255];
   logic [31:0] mem2 [0:255];
   logic [31:0] m2_pipe;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();
   mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2();

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_STARVE(4)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT2), .MAX_STARVE(4)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory model for u_dut1: one-edge read latency
   always @(posedge clk) begin
      bus1.mem_rdata <= mem1[bus1.mem_addr[9:2]];
      if (bus1.mem_we) mem1[bus1.mem_addr[9:2]] <= merge(mem1[bus1.mem_addr[9:2]], bus1.mem_wdata, bus1.mem_wmask);
   end

   // Memory model for u_dut2: two-edge read latency
   always @(posedge clk) begin
      m2_pipe        <= mem2[bus2.mem_addr[9:2]];
      bus2.mem_rdata <= m2_pipe;
      if (bus2.mem_we) mem2[bus2.mem_addr[9:2]] <= merge(mem2[bus2.mem_addr[9:2]], bus2.mem_wdata, bus2.mem_wmask);
   end

   // Scoreboard monitor for u_dut2 plus write-strobe timing
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus2.f_gnt || bus2.d_gnt) gnt_cyc2 = cyc;
         if (bus2.mem_we) begin
            we_cnt2++;
            check("we_one_cycle_after_gnt", 32'(cyc), 32'(gnt_cyc2 + 1));
         end
         if (bus2.f_rvalid || bus2.d_rvalid) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_rvalid: f_rvalid=%0b d_rvalid=%0b with nothing outstanding (cycle %0d)",
                        bus2.f_rvalid, bus2.d_rvalid, cyc);
            end else begin
               mon_e = sbq.pop_front();
               check("rvalid_port", 32'({bus2.f_rvalid, bus2.d_rvalid}),
                     (mon_e.port == PORT_D) ? 32'h1 : 32'h2);
               check("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
               if (!mon_e.is_store) begin
                  check("rdata", (mon_e.port == PORT_D) ? bus2.d_rdata : bus2.f_rdata, mon_e.rdata);
               end
            end
         end
      end
   end

   task automatic issue2(input vec_t v);
      bit got;
      @(posedge clk); #1;
      if (v.port == PORT_D) begin
         bus2.d_req = 1'b1; bus2.d_we = v.we; bus2.d_addr = v.addr;
         bus2.d_wdata = v.wdata; bus2.d_wmask = v.wmask;
      end else begin
         bus2.f_req = 1'b1; bus2.f_addr = v.addr;
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if ((v.port == PORT_D) ? bus2.d_gnt : bus2.f_gnt) begin
            got = 1'b1;
            sbq.push_back('{v.port, v.we, v.exp, cyc + LAT2 + 1});
         end
      end
      check("table_grant_seen", 32'(got), 32'h1);
      @(posedge clk); #1;
      bus2.d_req = 1'b0;
      bus2.f_req = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clk);
      check(name, 32'(sbq.size()), 32'h0);
   endtask

   // Global time limit
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d expected responses outstanding", sbq.size());
      $fatal(1, "tb_mem_bus_arbiter timeout");
   end

   initial begin
      int ng;
      int prev;
      bit fg_seen;

      vecs[0] = '{PORT_D, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0};
      vecs[1] = '{PORT_D, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEADBEEF};
      vecs[2] = '{PORT_D, 1'b1, 32'h200, 32'h11223344, 4'hF, 32'h0};
      vecs[3] = '{PORT_D, 1'b1, 32'h200, 32'h0000AA00, 4'b0010, 32'h0};
      vecs[4] = '{PORT_D, 1'b0, 32'h200, 32'h0,        4'h0, 32'h1122AA44};
      vecs[5] = '{PORT_F, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEADBEEF};
      vecs[6] = '{PORT_D, 1'b1, 32'h300, 32'hA5A5A5A5, 4'b1001, 32'h0};
      vecs[7] = '{PORT_F, 1'b0, 32'h300, 32'h0,        4'h0, 32'hA50000A5};
      order = '{PORT_D, PORT_D, PORT_D, PORT_D, PORT_F, PORT_D, PORT_D, PORT_D, PORT_D, PORT_F};

      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'h0;
         mem2[i] = 32'h0;
      end
      mem1[4] = 32'h00500093;

      bus1.f_req = 1'b0; bus1.f_addr = 32'h0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = 32'h0; bus1.d_wdata = 32'h0; bus1.d_wmask = 4'h0;
      bus2.f_req = 1'b0; bus2.f_addr = 32'h0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
      bus2.d_addr = 32'h0; bus2.d_wdata = 32'h0; bus2.d_wmask = 4'h0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_addr", bus2.mem_addr, 32'h0);
      check("rst_mem_we", 32'(bus2.mem_we), 32'h0);
      check("rst_rvalid", 32'({bus2.f_rvalid, bus2.d_rvalid}), 32'h0);
      check("rst_f_rdata", bus2.f_rdata, 32'h0);
      check("rst_d_rdata", bus1.d_rdata, 32'h0);
      rst_n = 1'b1;

      // Single fetch on the MEM_LAT=1 instance
      @(posedge clk); #1;
      bus1.f_req = 1'b1; bus1.f_addr = 32'h10;
      @(negedge clk);
      check("f1_gnt_t", 32'(bus1.f_gnt), 32'h1);
      check("f1_no_d_gnt_t", 32'(bus1.d_gnt), 32'h0);
      @(posedge clk); #1;
      bus1.f_req = 1'b0;
      @(negedge clk);
      check("f1_rvalid_t1", 32'(bus1.f_rvalid), 32'h0);
      check("f1_mem_addr_t1", bus1.mem_addr, 32'h10);
      @(negedge clk);
      check("f1_rvalid_t2", 32'(bus1.f_rvalid), 32'h1);
      check("f1_rdata_t2", bus1.f_rdata, 32'h00500093);
      @(negedge clk);
      check("f1_rvalid_t3", 32'(bus1.f_rvalid), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("f1_rdata_t5", bus1.f_rdata, 32'h00500093);

      // Table of single transactions on the MEM_LAT=2 instance
      for (int i = 0; i < 8; i++) issue2(vecs[i]);
      drain("table_drain");
      check("store_strobe_count", 32'(we_cnt2), 32'h4);

      // Continuous contention: starvation guard forces every fifth grant to F
      @(posedge clk); #1;
      bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h100;
      bus2.f_req = 1'b1; bus2.f_addr = 32'h200;
      ng = 0;
      prev = 0;
      for (int k = 0; k < 80 && ng < 10; k++) begin
         @(negedge clk);
         if (bus2.f_gnt || bus2.d_gnt) begin
            check("contend_order", 32'({bus2.f_gnt, bus2.d_gnt}),
                  (order[ng] == PORT_D) ? 32'h1 : 32'h2);
            if (ng > 0) check("contend_spacing", 32'(cyc - prev), 32'(LAT2 + 2));
            sbq.push_back('{order[ng], 1'b0,
                            (order[ng] == PORT_D) ? 32'hDEADBEEF : 32'h1122AA44, cyc + LAT2 + 1});
            prev = cyc;
            ng++;
         end
      end
      check("contend_grant_count", 32'(ng), 32'd10);
      @(posedge clk); #1;
      bus2.d_req = 1'b0;
      bus2.f_req = 1'b0;
      drain("contend_drain");

      // Fetch request pulsed while busy: must be ignored entirely
      check("wd_starve_before", 32'(u_dut2.starve_cnt_r), 32'h0);
      @(posedge clk); #1;
      bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h300;
      @(negedge clk);
      check("wd_d_gnt", 32'(bus2.d_gnt), 32'h1);
      sbq.push_back('{PORT_D, 1'b0, 32'hA50000A5, cyc + LAT2 + 1});
      @(posedge clk); #1;
      bus2.d_req = 1'b0;
      bus2.f_req = 1'b1; bus2.f_addr = 32'h100;
      fg_seen = 1'b0;
      @(negedge clk);
      if (bus2.f_gnt) fg_seen = 1'b1;
      @(posedge clk); #1;
      bus2.f_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus2.f_gnt) fg_seen = 1'b1;
      end
      check("wd_no_f_gnt", 32'(fg_seen), 32'h0);
      check("wd_starve_after", 32'(u_dut2.starve_cnt_r), 32'h0);
      drain("wd_drain");

      // Reset during the write-strobe cycle of a store
      @(posedge clk); #1;
      bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_addr = 32'h3F0;
      bus2.d_wdata = 32'h12345678; bus2.d_wmask = 4'hF;
      @(negedge clk);
      check("rst_store_gnt", 32'(bus2.d_gnt), 32'h1);
      @(posedge clk); #1;
      check("rst_we_before", 32'(bus2.mem_we), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_we_async", 32'(bus2.mem_we), 32'h0);
      check("rst_d_gnt_async", 32'(bus2.d_gnt), 32'h0);
      check("rst_d_rvalid_async", 32'(bus2.d_rvalid), 32'h0);
      bus2.d_req = 1'b0;
      bus2.f_req = 1'b1; bus2.f_addr = 32'h10;
      @(negedge clk);
      check("rst_f_gnt_held", 32'(bus2.f_gnt), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_f_gnt_first", 32'(bus2.f_gnt), 32'h1);
      sbq.push_back('{PORT_F, 1'b0, 32'h0, cyc + LAT2 + 1});
      @(posedge clk); #1;
      bus2.f_req = 1'b0;
      drain("rst_drain");
      check("rst_d_hold_cleared", bus2.d_rdata, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_bus_arbiter

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port unified memory of the multi-cycle processor between two requesters.
  - Port F: the instruction-fetch stage.
  - Port D: the load/store stage.
- Grants one requester at a time and sequences the fixed-latency memory access.
- Returns read data and completion with a valid pulse.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, byte address width passed to memory.
- DATA_W, 32, data word width.
- MEM_LAT, 1, clock edges from address presented to mem_rdata valid; must be ≥1 (elaboration error otherwise).
- MAX_STARVE, 4, consecutive D grants while F is waiting before F is forced to win.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request; held with f_addr until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch request accepted (combinational, IDLE only)
- f_rvalid  out  1  one-cycle pulse, fetch data valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_* until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  byte write enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid / store complete
- d_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: clk is the only clock; rst_n is asynchronous, active-low, no synchronous reset.
- Reset values: all outputs 0, state IDLE, latency counter 0, starve counter 0, rdata hold registers 0.
- States:
  - IDLE: arbitrates.
  - ACCESS: memory busy for MEM_LAT cycles.
  - RESP: one cycle; mem_rdata valid, rvalid pulses.
  - RESP always returns to IDLE.
- Arbitration (cycle t, IDLE, comb):
  - Only d_req → D wins.
  - Only f_req → F wins.
  - Both requesting → D wins unless starve_cnt == MAX_STARVE, in which case F wins.
  - The winner's gnt = 1 in cycle t; the loser's gnt stays 0.
  - The winner's addr/we/wdata/wmask and port ID are latched at the edge ending t.
  - F transactions are reads: we = 0, wmask = 0.
- Starve counter:
  - Increments on each D grant while f_req = 1, saturating at MAX_STARVE.
  - Clears on an F grant or in any IDLE cycle with f_req = 0.
- Access sequence:
  - Cycles t+1 to t+MEM_LAT: state ACCESS; mem_addr, mem_wdata and mem_wmask driven from the latch.
  - mem_we = latched we during cycle t+1 only, giving a single write strobe per store.
  - Cycle t+MEM_LAT+1: state RESP; rvalid of the owning port = 1, and rdata of that port = mem_rdata (forwarded).
  - The same value is captured into that port's hold register, so rdata stays stable until that port's next rvalid.
  - Stores also pulse d_rvalid; d_rdata is then don't-care but is still captured.
  - Cycle t+MEM_LAT+2: IDLE; the earliest next gnt is this cycle.
- Timing: gnt→rvalid latency = MEM_LAT+1; back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- mem_addr when not busy: holds its last value; outside a transaction it is don't-care apart from reset value 0.
- Boundary conditions:
  - req deasserted before gnt: legal; no transaction, no counter change.
  - req asserted during ACCESS/RESP: no gnt; arbitrated in the next IDLE.
  - Requester dropping req after gnt: ignored, because the transaction is already latched.
  - Reset mid-transaction: immediate return to IDLE; mem_we, gnt and rvalid drop asynchronously; the transaction is discarded with no rvalid.
  - Starve counter at MAX_STARVE with F not requesting: clears; D is served normally.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - port-ID enum {PORT_F, PORT_D}
  - default MEM_LAT/MAX_STARVE constants
- One sub-module, mem_arb_pick: combinational winner select from f_req, d_req, starve_cnt and MAX_STARVE.
- Counters and FSM live in the top module.

Test Plan:
- Single fetch, MEM_LAT=1: f_req, f_addr=0x10, memory word 0x00500093.
  - f_gnt at t, f_rvalid at t+2 with f_rdata=0x00500093.
  - Back in IDLE at t+3; f_rdata still 0x00500093 at t+5.
- Store then load, MEM_LAT=2:
  - Store d_addr=0x100, d_wdata=0xDEADBEEF, d_wmask=0xF: mem_we high exactly one cycle (t+1); d_rvalid at t+3.
  - Following load of 0x100: d_rdata=0xDEADBEEF.
- Simultaneous requests, MAX_STARVE=4: f_req and d_req held continuously.
  - Grant order D,D,D,D,F,D,D,D,D,F.
  - Grants spaced MEM_LAT+2 cycles apart.
- Byte-masked store: d_wmask=4'b0010 to a word holding 0x11223344 with d_wdata=0x0000AA00 → read-back 0x1122AA44.
- Reset mid-ACCESS: rst_n low at t+1 of a store.
  - mem_we, d_gnt and d_rvalid go 0 immediately.
  - No d_rvalid after release; a new f_req is granted in the first cycle after rst_n rises.
- Request withdrawal: f_req pulsed for one cycle while the arbiter is in ACCESS → no f_gnt, no f_rvalid, starve_cnt unchanged.
